// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension sequencer: FSM states, funct3 codes,
// ALU opcodes used by the ALU control decode, and a small elaboration helper.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/muldiv_lat_cnt.sv
// Loadable down-counter with a zero flag; it holds at zero rather than wrapping.
module muldiv_lat_cnt #(
    parameter int CW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_dec,
    output logic          o_zero
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/muldiv_seq.sv
// Sequencer for the iterative mul/div units: load pulse, act strobes, writeback handshake.
// Optional macro DIV_ZERO_EARLY_EN: a divide by zero finishes after a single dact cycle.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int W       = 32,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    input  logic [2:0] req_funct3,
    input  logic [4:0] req_rd,
    input  logic       req_useRd,
    output logic       req_ready,
    input  logic       kill,
    input  logic       div_zero,
    output logic       mul_load,
    output logic       div_load,
    output logic       mact,
    output logic       dact,
    output logic       mul_res_sel,
    output logic       div_res_sel,
    output logic       busy,
    output logic       stall,
    output logic       wb_valid,
    input  logic       wb_ready,
    output logic [4:0] wb_rd,
    output logic       wb_useRd,
    output logic       wb_div,
    output logic [1:0] dbg_state
);

    localparam int CW = $clog2(max_int(MUL_LAT, DIV_LAT)) + 1;

    if (W < 1 || MUL_LAT < 1 || DIV_LAT < 1) begin : g_bad_param
        $error("muldiv_seq: W, MUL_LAT and DIV_LAT must all be >= 1");
    end

    // Handshakes: a request is taken on an edge where req_valid & req_ready & ~kill;
    // a result retires on an edge where wb_valid & wb_ready & ~kill.
    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_funct3;
    logic [4:0] r_rd;
    logic       r_useRd;
    logic       w_accept;
    logic       w_is_div;
    logic       w_cnt_zero;
    logic [CW-1:0] w_load_val;

    assign w_is_div = r_funct3[2];
    assign w_accept = (r_state == IDLE) && req_valid && !kill;

`ifdef DIV_ZERO_EARLY_EN
    assign w_load_val = (w_is_div && div_zero) ? '0 :
                        w_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
`else
    logic w_div_zero_unused;
    assign w_div_zero_unused = div_zero;
    assign w_load_val = w_is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
`endif

    muldiv_lat_cnt #(
        .CW(CW)
    ) u_lat_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_load    (r_state == LOAD),
        .i_load_val(w_load_val),
        .i_dec     (r_state == RUN),
        .o_zero    (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_funct3 <= '0;
            r_rd     <= '0;
            r_useRd  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_funct3 <= req_funct3;
                r_rd     <= req_rd;
                r_useRd  <= req_useRd;
            end
        end
    end

    // kill wins over every transition, including a same-cycle request in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = RUN;
            RUN:     if (w_cnt_zero) w_state_nxt = DONE;
            DONE:    if (wb_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if (kill) w_state_nxt = IDLE;
    end

    assign req_ready   = (r_state == IDLE);
    assign stall       = req_valid && !req_ready;
    assign busy        = (r_state != IDLE);
    assign mul_load    = (r_state == LOAD) && !w_is_div;
    assign div_load    = (r_state == LOAD) && w_is_div;
    assign mact        = (r_state == RUN) && !w_is_div;
    assign dact        = (r_state == RUN) && w_is_div;
    assign wb_valid    = (r_state == DONE);
    assign mul_res_sel = (r_funct3 != F3_MUL);
    assign div_res_sel = r_funct3[1];
    assign wb_div      = w_is_div;
    assign wb_rd       = r_rd;
    assign wb_useRd    = r_useRd;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a cycle-timeline reference model.
module tb_muldiv_seq;

    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [2:0] req_funct3;
    logic [4:0] req_rd;
    logic       req_useRd;
    logic       req_ready;
    logic       kill;
    logic       div_zero;
    logic       mul_load, div_load, mact, dact;
    logic       mul_res_sel, div_res_sel;
    logic       busy, stall, wb_valid, wb_ready;
    logic [4:0] wb_rd;
    logic       wb_useRd, wb_div;
    logic [1:0] dbg_state;

    int total = 0;
    int bad   = 0;

    muldiv_seq #(.W(32), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_funct3(req_funct3), .req_rd(req_rd),
        .req_useRd(req_useRd), .req_ready(req_ready), .kill(kill),
        .div_zero(div_zero), .mul_load(mul_load), .div_load(div_load),
        .mact(mact), .dact(dact), .mul_res_sel(mul_res_sel),
        .div_res_sel(div_res_sel), .busy(busy), .stall(stall),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
        .wb_useRd(wb_useRd), .wb_div(wb_div), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Number of act cycles an op should take.
    function automatic int ref_lat(input logic [2:0] f3, input logic dz);
        if (!f3[2]) return MUL_LAT;
`ifdef DIV_ZERO_EARLY_EN
        if (dz) return 1;
`endif
        return DIV_LAT;
    endfunction

    function automatic logic [7:0] strobes();
        return {mul_load, div_load, mact, dact, wb_valid, busy, req_ready, stall};
    endfunction

    function automatic logic [8:0] sels();
        return {mul_res_sel, div_res_sel, wb_div, wb_rd, wb_useRd};
    endfunction

    task automatic monitor_no_wb(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk); #1;
            if (wb_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s: wb_valid seen in %0d cycles, required 0", name, seen);
        end
    endtask

    // Called just after a negedge with the sequencer idle. Offers one op and checks
    // every cycle against the expected timeline: LOAD at k=1, act for k=2..lat+1,
    // DONE for k=lat+2..lat+2+bp, IDLE after. Returns just after the IDLE negedge.
    task automatic do_op(input string name, input logic [2:0] f3, input logic [4:0] rd,
                         input logic use_rd, input logic dz, input int bp,
                         input int kill_at, input logic hold);
        int lat, last_k;
        logic is_load, is_run, is_done, is_idle;
        logic [7:0] exp_s;
        logic [8:0] exp_sel;
        lat    = ref_lat(f3, dz);
        last_k = lat + 2 + bp;
        exp_sel = {(f3 != 3'b000), f3[1], f3[2], rd, use_rd};
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rd     = rd;
        req_useRd  = use_rd;
        kill       = 1'b0;
        wb_ready   = 1'($urandom_range(0, 1));
        div_zero   = 1'($urandom_range(0, 1));
        #1;
        total++;
        if (req_ready !== 1'b1 || stall !== 1'b0) begin
            bad++;
            $display("FAIL %s accept: ready/stall=%b%b required 10", name, req_ready, stall);
        end
        for (int k = 1; k <= last_k + 1; k++) begin
            @(negedge clk);
            is_load = (k == 1);
            is_run  = (k >= 2) && (k <= lat + 1);
            is_done = (k >= lat + 2) && (k <= last_k);
            is_idle = (k == last_k + 1);
            req_valid = hold;
            div_zero  = is_load ? dz : 1'($urandom_range(0, 1));
            wb_ready  = is_done ? (k == last_k) : 1'($urandom_range(0, 1));
            kill      = (k == kill_at);
            #1;
            exp_s = {is_load & ~f3[2], is_load & f3[2], is_run & ~f3[2], is_run & f3[2],
                     is_done, ~is_idle, is_idle, hold & ~is_idle};
            total++;
            if (strobes() !== exp_s) begin
                bad++;
                $display("FAIL %s strobes k=%0d: got %b required %b", name, k, strobes(), exp_s);
            end
            total++;
            if (sels() !== exp_sel) begin
                bad++;
                $display("FAIL %s selects k=%0d: got %b required %b", name, k, sels(), exp_sel);
            end
            if (k == kill_at) begin
                @(negedge clk);
                kill = 1'b0;
                req_valid = 1'b0;
                #1;
                total++;
                if (strobes() !== 8'b0000_0010) begin
                    bad++;
                    $display("FAIL %s after kill: got %b required 00000010", name, strobes());
                end
                monitor_no_wb({name, " dropped"}, 40);
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0; req_funct3 = '0; req_rd = '0; req_useRd = 1'b0;
        kill = 1'b0; div_zero = 1'b0; wb_ready = 1'b0;
        #12;
        total++;
        if (strobes() !== 8'b0000_0010 || sels() !== 9'b1_0000_0000 && sels() !== 9'b0) begin
            bad++;
            $display("FAIL reset strobes/sel: got %b/%b required 00000010/000000000", strobes(), sels());
        end
        req_valid = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset stall: got ready=%b stall=%b required 1 0", req_ready, stall);
        end
        total++;
        if (wb_rd !== 5'd0 || wb_useRd !== 1'b0 || wb_div !== 1'b0 || mul_res_sel !== 1'b0) begin
            bad++;
            $display("FAIL reset captured: got rd=%0d use=%b div=%b msel=%b required 0", wb_rd, wb_useRd, wb_div, mul_res_sel);
        end
        req_valid = 1'b0;
        #4 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mul();
        do_op("mul", 3'b000, 5'd5, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_remu();
        do_op("remu", 3'b111, 5'd17, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op("b2b_divu", 3'b101, 5'd3, 1'b0, 1'b0, 0, 0, 1'b0);
        do_op("b2b_mulhu", 3'b011, 5'd30, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        do_op("bp_mulhsu", 3'b010, 5'd12, 1'b1, 1'b0, 5, 0, 1'b1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        total++;
        if (strobes() !== 8'b1000_0100 || wb_rd !== 5'd12) begin
            bad++;
            $display("FAIL bp held accept: got %b rd=%0d required 10000100 rd=12", strobes(), wb_rd);
        end
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL bp drain: busy=%b required 0", busy);
        end
    endtask

    task automatic test_kill();
        do_op("kill_div", 3'b100, 5'd8, 1'b1, 1'b0, 0, 4, 1'b0);
        do_op("post_kill_mulh", 3'b001, 5'd9, 1'b1, 1'b0, 0, 0, 1'b0);
        do_op("kill_done", 3'b000, 5'd2, 1'b1, 1'b0, 2, MUL_LAT + 2, 1'b0);
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b000; kill = 1'b1;
        @(negedge clk);
        req_valid = 1'b0; kill = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || mul_load !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL kill_idle: busy=%b mul_load=%b ready=%b required 0 0 1", busy, mul_load, req_ready);
        end
    endtask

    task automatic test_div_zero();
        do_op("div_zero", 3'b100, 5'd21, 1'b1, 1'b1, 0, 0, 1'b0);
        do_op("rem_zero", 3'b110, 5'd22, 1'b0, 1'b1, 1, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 20; n++) begin
            logic [2:0] f3;
            logic dz;
            int bp, kat;
            f3  = 3'($urandom_range(0, 7));
            dz  = 1'($urandom_range(0, 1));
            bp  = $urandom_range(0, 3);
            kat = 0;
            if ($urandom_range(0, 4) == 0) kat = $urandom_range(1, ref_lat(f3, dz) + 2 + bp);
            do_op("random", f3, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), dz, bp, kat,
                  1'($urandom_range(0, 1)) & (kat == 0) ? 1'b0 : 1'b0);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = 3'b110; req_rd = 5'd7; req_useRd = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (strobes() !== 8'b0000_0010) begin
            bad++;
            $display("FAIL async_reset: got %b required 00000010", strobes());
        end
        #4 rst = 1'b0;
        @(negedge clk); #1;
        total++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || wb_rd !== 5'd0) begin
            bad++;
            $display("FAIL async_release: ready=%b busy=%b rd=%0d required 1 0 0", req_ready, busy, wb_rd);
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_remu();
        test_back_to_back();
        test_backpressure();
        @(negedge clk);
        test_kill();
        @(negedge clk);
        test_div_zero();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
